// File: rtl/inst_fetch_stage_if.sv
// Fetch-stage bundle: redirect/hold controls, instruction-memory port and IF/ID outputs.
// The fetch stage takes the master side; the core/testbench environment takes the slave side.
interface inst_fetch_stage_if;
  logic        stall;
  logic        jmp;
  logic [31:0] new_inst_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic        misalign_err;

  modport master (
    input  stall, jmp, new_inst_addr, imem_rdata,
    output imem_addr, if_id_pc, if_id_inst, if_id_valid, misalign_err
  );

  modport slave (
    output stall, jmp, new_inst_addr, imem_rdata,
    input  imem_addr, if_id_pc, if_id_inst, if_id_valid, misalign_err
  );
endinterface

// File: rtl/inst_fetch_stage.sv
// PC generator and IF/ID register for the 5-stage RISC-V core.
// imem_addr is the next PC, so a 1-cycle synchronous imem always returns the word at pc.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  inst_fetch_stage_if.master     bus
);

  logic [31:0] pc_p0;
  logic [31:0] pc_p1;
  logic [31:0] inst_p1;
  logic        vld_p1;
  logic        err_p1;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Next-PC select; depends only on reset, jmp and stall, never on imem_rdata
  always_comb begin
    bus.imem_addr = pc_inc(pc_p0);
    if (!rst_n)
      bus.imem_addr = RESET_ADDR;
    else if (bus.jmp)
      bus.imem_addr = word_align(bus.new_inst_addr);
    else if (bus.stall)
      bus.imem_addr = pc_p0;
  end

  // PC (p0) -> IF/ID register (p1)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_p0   <= RESET_ADDR;
      pc_p1   <= 32'h0000_0000;
      inst_p1 <= NOP_INST;
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
    end else if (bus.jmp) begin
      pc_p0   <= word_align(bus.new_inst_addr);
      pc_p1   <= pc_p0;
      inst_p1 <= NOP_INST;
      vld_p1  <= 1'b0;
      err_p1  <= |bus.new_inst_addr[1:0];
    end else if (bus.stall) begin
      err_p1  <= 1'b0;
    end else begin
      pc_p0   <= pc_inc(pc_p0);
      pc_p1   <= pc_p0;
      inst_p1 <= bus.imem_rdata;
      vld_p1  <= 1'b1;
      err_p1  <= 1'b0;
    end
  end

  assign bus.if_id_pc     = pc_p1;
  assign bus.if_id_inst   = inst_p1;
  assign bus.if_id_valid  = vld_p1;
  assign bus.misalign_err = err_p1;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Scoreboard bench for inst_fetch_stage: directed cycles push expectations, a monitor compares.
// Two instances share the stimulus; dut1 uses a reset address near the top of memory.
module tb_inst_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        jmp;
  logic [31:0] nia;
  logic        sel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        v;
    logic        e;
  } exp_t;

  exp_t q[$];

  inst_fetch_stage_if b0();
  inst_fetch_stage_if b1();

  assign b0.stall = stall;
  assign b0.jmp = jmp;
  assign b0.new_inst_addr = nia;
  assign b1.stall = stall;
  assign b1.jmp = jmp;
  assign b1.new_inst_addr = nia;

  inst_fetch_stage #(.RESET_ADDR(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.master)
  );
  inst_fetch_stage #(.RESET_ADDR(32'hFFFF_FFF8), .NOP_INST(32'h0000_0013)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Synchronous instruction memories, one-cycle latency
  always @(posedge clk) begin
    b0.imem_rdata <= w(b0.imem_addr);
    b1.imem_rdata <= w(b1.imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: imem_addr sampled mid-cycle, IF/ID sampled just after the edge
  initial begin
    exp_t e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = e.sel ? b1.imem_addr : b0.imem_addr;
        @(posedge clk);
        #2;
        chk("imem_addr", a, e.addr);
        chk("if_id_pc", e.sel ? b1.if_id_pc : b0.if_id_pc, e.pc);
        chk("if_id_inst", e.sel ? b1.if_id_inst : b0.if_id_inst, e.inst);
        chk("if_id_valid", {31'd0, e.sel ? b1.if_id_valid : b0.if_id_valid}, {31'd0, e.v});
        chk("misalign_err", {31'd0, e.sel ? b1.misalign_err : b0.misalign_err}, {31'd0, e.e});
      end
    end
  end

  // One cycle: drive inputs, push expected imem_addr now and IF/ID after the next edge
  task automatic cyc(input logic r, input logic s, input logic j, input logic [31:0] n,
                     input logic [31:0] ea, input logic [31:0] epc, input logic [31:0] ei,
                     input logic ev, input logic ee);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    stall = s;
    jmp = j;
    nia = n;
    e.sel = sel;
    e.addr = ea;
    e.pc = epc;
    e.inst = ei;
    e.v = ev;
    e.e = ee;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    jmp = 1'b0;
    nia = 32'h0;
    sel = 1'b0;

    // T1 reset held two cycles
    cyc(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h13, 0, 0);
    cyc(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h13, 0, 0);
    // T2 straight-line fetch
    cyc(1, 0, 0, 32'h0, 32'h4, 32'h0, w(32'h0), 1, 0);
    cyc(1, 0, 0, 32'h0, 32'h8, 32'h4, w(32'h4), 1, 0);
    // T3 stall three cycles at pc=8
    cyc(1, 1, 0, 32'h0, 32'h8, 32'h4, w(32'h4), 1, 0);
    cyc(1, 1, 0, 32'h0, 32'h8, 32'h4, w(32'h4), 1, 0);
    cyc(1, 1, 0, 32'h0, 32'h8, 32'h4, w(32'h4), 1, 0);
    cyc(1, 0, 0, 32'h0, 32'hC, 32'h8, w(32'h8), 1, 0);
    cyc(1, 0, 0, 32'h0, 32'h10, 32'hC, w(32'hC), 1, 0);
    // T4 redirect wins over stall
    cyc(1, 1, 1, 32'h40, 32'h40, 32'h10, 32'h13, 0, 0);
    cyc(1, 0, 0, 32'h0, 32'h44, 32'h40, w(32'h40), 1, 0);
    // T5 misaligned target
    cyc(1, 0, 1, 32'h42, 32'h40, 32'h44, 32'h13, 0, 1);
    cyc(1, 0, 0, 32'h0, 32'h44, 32'h40, w(32'h40), 1, 0);
    // Back-to-back redirects, second one while IF/ID holds a bubble
    cyc(1, 0, 1, 32'h80, 32'h80, 32'h44, 32'h13, 0, 0);
    cyc(1, 0, 1, 32'h101, 32'h100, 32'h80, 32'h13, 0, 1);
    cyc(1, 0, 0, 32'h0, 32'h104, 32'h100, w(32'h100), 1, 0);
    // Reset during a stall
    cyc(0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h13, 0, 0);
    cyc(1, 0, 0, 32'h0, 32'h4, 32'h0, w(32'h0), 1, 0);

    // T6 on dut1: PC wraps past 32'hFFFF_FFFC, then reset mid-stall
    sel = 1'b1;
    cyc(0, 0, 0, 32'h0, 32'hFFFF_FFF8, 32'h0, 32'h13, 0, 0);
    cyc(1, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, w(32'hFFFF_FFF8), 1, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, w(32'hFFFF_FFFC), 1, 0);
    cyc(1, 0, 0, 32'h0, 32'h4, 32'h0, w(32'h0), 1, 0);
    cyc(1, 1, 0, 32'h0, 32'h4, 32'h0, w(32'h0), 1, 0);
    cyc(0, 1, 0, 32'h0, 32'hFFFF_FFF8, 32'h0, 32'h13, 0, 0);
    cyc(1, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, w(32'hFFFF_FFF8), 1, 0);

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
